// File: rtl/sersub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// The overflow output is compiled in only with SERSUB_OVERFLOW_EN.
package sersub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIX   = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic MODE_TWOS = 1'b0;
  localparam logic MODE_ONES = 1'b1;

endpackage : sersub_pkg

// File: rtl/serial_subtractor_full_sub_cell.sv
// Single-bit combinational full subtractor: d = a - b - bin, bout on underflow.
module full_sub_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  always_comb begin
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule : full_sub_cell

// File: rtl/serial_subtractor.sv
// Bit-serial A - B, one bit per clock, two's or ones' complement (end-around borrow).
// Define SERSUB_OVERFLOW_EN to add the signed overflow output and its register.
module serial_subtractor
  import sersub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
`ifdef SERSUB_OVERFLOW_EN
  output logic             overflow,
`endif
  output logic             borrow
);

  // Handshake: start is sampled only in IDLE or DONE and is ignored while busy;
  // done is a one-cycle pulse and diff/borrow/overflow hold until the next done.

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;

  logic             cell_d;
  logic             cell_bout;
  logic [WIDTH-1:0] shift_res;

  full_sub_cell u_cell (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .bin  (br_q),
    .d    (cell_d),
    .bout (cell_bout)
  );

  // Each new difference bit enters at the MSB, so after WIDTH shifts bit 0 is the LSB.
  assign shift_res = {cell_d, res_q[WIDTH-1:1]};

`ifdef SERSUB_OVERFLOW_EN
  logic ovf_pend_q, ovf_pend_d;
  logic overflow_q, overflow_d;
  logic raw_ovf;

  // On the last shift the operand LSBs are the original MSBs and cell_d is the raw result MSB.
  assign raw_ovf = (a_sh_q[0] ^ b_sh_q[0]) & (cell_d ^ a_sh_q[0]);
`endif

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_d    = res_q;
    br_d     = br_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    diff_d   = diff_q;
    borrow_d = borrow_q;
`ifdef SERSUB_OVERFLOW_EN
    ovf_pend_d = ovf_pend_q;
    overflow_d = overflow_q;
`endif

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          mode_d  = mode;
          res_d   = '0;
          br_d    = 1'b0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end

      SHIFT: begin
        res_d  = shift_res;
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        br_d   = cell_bout;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          if ((mode_q == MODE_ONES) && cell_bout) begin
            state_d = FIX;
`ifdef SERSUB_OVERFLOW_EN
            ovf_pend_d = raw_ovf;
`endif
          end else begin
            state_d  = DONE;
            done_d   = 1'b1;
            busy_d   = 1'b0;
            diff_d   = shift_res;
            borrow_d = cell_bout;
`ifdef SERSUB_OVERFLOW_EN
            overflow_d = raw_ovf;
`endif
          end
        end
      end

      FIX: begin
        // End-around borrow: only reached when the raw borrow-out was 1, still held in br_q.
        res_d    = res_q - WIDTH'(1);
        diff_d   = res_q - WIDTH'(1);
        borrow_d = br_q;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = DONE;
`ifdef SERSUB_OVERFLOW_EN
        overflow_d = ovf_pend_q;
`endif
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      a_sh_q     <= '0;
      b_sh_q     <= '0;
      res_q      <= '0;
      br_q       <= 1'b0;
      cnt_q      <= '0;
      mode_q     <= MODE_TWOS;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      diff_q     <= '0;
      borrow_q   <= 1'b0;
`ifdef SERSUB_OVERFLOW_EN
      ovf_pend_q <= 1'b0;
      overflow_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      a_sh_q     <= a_sh_d;
      b_sh_q     <= b_sh_d;
      res_q      <= res_d;
      br_q       <= br_d;
      cnt_q      <= cnt_d;
      mode_q     <= mode_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      diff_q     <= diff_d;
      borrow_q   <= borrow_d;
`ifdef SERSUB_OVERFLOW_EN
      ovf_pend_q <= ovf_pend_d;
      overflow_q <= overflow_d;
`endif
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign diff   = diff_q;
  assign borrow = borrow_q;
`ifdef SERSUB_OVERFLOW_EN
  assign overflow = overflow_q;
`endif

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=8); overflow checks compile with SERSUB_OVERFLOW_EN.
module tb_serial_subtractor;

  localparam int W     = 8;
  localparam int LIMIT = 40;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         mode;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow;
`ifdef SERSUB_OVERFLOW_EN
  logic         overflow;
`endif

  int tests_run;
  int tests_failed;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .mode     (mode),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .diff     (diff),
`ifdef SERSUB_OVERFLOW_EN
    .overflow (overflow),
`endif
    .borrow   (borrow)
  );

  // clock block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at #1 after edge 0; returns edges counted from edge 0 (inclusive) until done is seen.
  task automatic wait_done(input logic [W-1:0] held_val, input int inject_at,
                           output int lat, output bit held_ok);
    lat     = 1;
    held_ok = 1'b1;
    while (done !== 1'b1 && lat < LIMIT) begin
      if (diff !== held_val) held_ok = 1'b0;
      if (inject_at != 0 && lat == inject_at) begin
        a     = 8'hAA;
        b     = 8'h11;
        mode  = ~mode;
        start = 1'b1;
      end else if (inject_at != 0 && lat == inject_at + 1) begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    if (done !== 1'b1) check_eq("done_timeout", 32'd0, 32'd1);
  endtask

  // Called at #1 after a posedge; leaves the bench at #1 after a posedge.
  task automatic run_op(input string tag, input logic m, input logic [W-1:0] op_a,
                        input logic [W-1:0] op_b, input logic [W-1:0] exp_diff,
                        input logic exp_borrow, input logic exp_ovf, input int exp_lat,
                        input int inject_at);
    int           lat;
    bit           held_ok;
    logic [W-1:0] held_val;
    held_val = diff;
    mode  = m;
    a     = op_a;
    b     = op_b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check_eq({tag, "_busy"}, 32'(busy), 32'd1);
    wait_done(held_val, inject_at, lat, held_ok);
    check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check_eq({tag, "_diff"}, 32'(diff), 32'(exp_diff));
    check_eq({tag, "_borrow"}, 32'(borrow), 32'(exp_borrow));
    check_eq({tag, "_held"}, 32'(held_ok), 32'd1);
`ifdef SERSUB_OVERFLOW_EN
    check_eq({tag, "_ovf"}, 32'(overflow), 32'(exp_ovf));
`else
    if (exp_ovf) begin end
`endif
    @(posedge clk);
    #1;
    check_eq({tag, "_pulse"}, 32'(done), 32'd0);
    check_eq({tag, "_idle"}, 32'(busy), 32'd0);
    check_eq({tag, "_hold"}, 32'(diff), 32'(exp_diff));
  endtask

  initial begin
    int  lat;
    bit  held_ok;
    tests_run    = 0;
    tests_failed = 0;
    rst_n = 1'b0;
    start = 1'b0;
    mode  = 1'b0;
    a     = '0;
    b     = '0;

    // reset values
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_diff", 32'(diff), 32'd0);
    check_eq("rst_borrow", 32'(borrow), 32'd0);
`ifdef SERSUB_OVERFLOW_EN
    check_eq("rst_ovf", 32'(overflow), 32'd0);
`endif
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    //     tag       mode a      b      diff   brw   ovf   lat inject
    run_op("t5m3",  1'b0, 8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 9,  0);
    run_op("t3m5",  1'b0, 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 9,  3);
    run_op("o2m5",  1'b1, 8'h02, 8'h05, 8'hFC, 1'b1, 1'b0, 10, 0);
    run_op("o7m2",  1'b1, 8'h07, 8'h02, 8'h05, 1'b0, 1'b0, 9,  0);
    run_op("o0m0",  1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 9,  0);
    run_op("o0mff", 1'b1, 8'h00, 8'hFF, 8'h00, 1'b1, 1'b0, 10, 0);
    run_op("t80m1", 1'b0, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 9,  0);
    run_op("t10m1", 1'b0, 8'h10, 8'h01, 8'h0F, 1'b0, 1'b0, 9,  0);
    run_op("t7fmff",1'b0, 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, 9,  0);

    // reset mid-SHIFT aborts at once
    mode  = 1'b0;
    a     = 8'h44;
    b     = 8'h11;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    check_eq("mid_rst_done", 32'(done), 32'd0);
    check_eq("mid_rst_diff", 32'(diff), 32'd0);
    check_eq("mid_rst_borrow", 32'(borrow), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_op("post_rst", 1'b0, 8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 9, 0);

    // back-to-back: start held through the DONE cycle
    mode  = 1'b0;
    a     = 8'h05;
    b     = 8'h03;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(8'h02, 0, lat, held_ok);
    check_eq("b2b1_lat", 32'(lat), 32'd9);
    check_eq("b2b1_diff", 32'(diff), 32'h02);
    mode  = 1'b1;
    a     = 8'h02;
    b     = 8'h05;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check_eq("b2b_no_gap", 32'(busy), 32'd1);
    wait_done(8'h02, 0, lat, held_ok);
    check_eq("b2b2_spacing", 32'(lat), 32'd10);
    check_eq("b2b_first_held", 32'(held_ok), 32'd1);
    check_eq("b2b2_diff", 32'(diff), 32'hFC);
    check_eq("b2b2_borrow", 32'(borrow), 32'd1);
    @(posedge clk);
    #1;
    check_eq("b2b2_pulse", 32'(done), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_serial_subtractor
